// File: rtl/home_cell_particle_streamer_if.sv
// home_cell_particle_streamer_if: position cache read port plus particle valid/ready stream
interface home_cell_particle_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] cache_rd_address;
  logic cache_rden;
  logic [3*DATA_WIDTH-1:0] cache_rd_data;
  logic [3*DATA_WIDTH-1:0] out_particle_data;
  logic [ADDR_WIDTH-1:0] out_particle_id;
  logic out_valid;
  logic in_ready;
  modport master (
    output cache_rd_address, cache_rden, out_particle_data, out_particle_id, out_valid,
    input cache_rd_data, in_ready
  );
  modport slave (
    input cache_rd_address, cache_rden, out_particle_data, out_particle_id, out_valid,
    output cache_rd_data, in_ready
  );
endinterface

// File: rtl/home_cell_particle_streamer.sv
// home_cell_particle_streamer: sweeps one cell's position cache into a 2-deep valid/ready stream
module home_cell_particle_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int PARTICLE_NUM = 220
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic motion_update_enable,
  home_cell_particle_streamer_if.master bus,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic busy,
  output logic done,
  output logic count_err
);
  localparam int W = 3*DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PMAX = ADDR_WIDTH'(PARTICLE_NUM);
  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic flush, cnt_issue, rd_issue, pend, rv, push, pop, bad, last, wp, rp;
  logic [1:0] stored;
  logic [2:0] load;
  logic [W-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_id [2];
  logic [ADDR_WIDTH-1:0] rid, next_addr, rd_addr, cnt_raw, cnt_fix;
  assign flush = rst | motion_update_enable;
  assign cnt_raw = bus.cache_rd_data[ADDR_WIDTH-1:0];
  assign bad = (|bus.cache_rd_data[W-1:ADDR_WIDTH]) || cnt_raw > PMAX;
  assign cnt_fix = bad ? PMAX : cnt_raw;
  // rv marks a particle word on the cache bus this cycle; it bypasses the FIFO when empty
  assign bus.out_valid = stored != 2'd0 || rv;
  assign bus.out_particle_data = stored != 2'd0 ? fifo_data[rp] : rv ? bus.cache_rd_data : '0;
  assign bus.out_particle_id = stored != 2'd0 ? fifo_id[rp] : rv ? rid : '0;
  assign pop = bus.out_valid && bus.in_ready;
  assign push = rv && !(stored == 2'd0 && pop);
  // buffered + returning + in-cache reads; bounding this by 2 is the credit that keeps the FIFO safe
  assign load = 3'(stored) + 3'(rv) + 3'(pend);
  assign rd_addr = state == WAIT_CNT ? ADDR_WIDTH'(1) : next_addr;
  assign last = rd_addr == (state == WAIT_CNT ? cnt_fix : particle_count);
  always_ff @(posedge clk) state <= flush ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? RD_CNT : IDLE;
      RD_CNT: nxt = WAIT_CNT;
      WAIT_CNT: nxt = cnt_fix == '0 ? DONE : last ? DRAIN : STREAM;
      STREAM: nxt = rd_issue && last ? DRAIN : STREAM;
      DRAIN: nxt = load == {2'b0, pop} ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    cnt_issue = state == IDLE && start && !motion_update_enable;
    rd_issue = (state == WAIT_CNT && cnt_fix != '0) || (state == STREAM && load < (pop ? 3'd3 : 3'd2));
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      bus.cache_rden <= 1'b0;
      bus.cache_rd_address <= '0;
      pend <= 1'b0;
      rv <= 1'b0;
      stored <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      bus.cache_rden <= cnt_issue | rd_issue;
      bus.cache_rd_address <= cnt_issue ? '0 : rd_issue ? rd_addr : bus.cache_rd_address;
      pend <= rd_issue;
      rv <= pend;
      wp <= push ? ~wp : wp;
      rp <= pop && stored != 2'd0 ? ~rp : rp;
      stored <= stored + 2'(push) - 2'(pop && stored != 2'd0);
    end
  end
  always_ff @(posedge clk) begin
    rid <= bus.cache_rd_address;
    if (rd_issue) next_addr <= rd_addr + ADDR_WIDTH'(1);
    if (push) begin
      fifo_data[wp] <= bus.cache_rd_data;
      fifo_id[wp] <= rid;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      particle_count <= '0;
      count_err <= 1'b0;
    end else if (cnt_issue) count_err <= 1'b0;
    else if (state == WAIT_CNT && !motion_update_enable) begin
      particle_count <= cnt_fix;
      count_err <= count_err | bad;
    end
  end
endmodule

// File: tb/tb_home_cell_particle_streamer.sv
// tb_home_cell_particle_streamer: directed sweeps against a registered-read position cache model
module tb_home_cell_particle_streamer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int PN = 220;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic motion_update_enable = 1'b0;
  logic [AW-1:0] particle_count;
  logic busy, done, count_err;
  int vectors = 0;
  int miscompares = 0;
  logic [3*DW-1:0] mem [256];
  int exp_id [32];
  int exp_addr [32];
  logic rdy [32];
  int done_c;
  home_cell_particle_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  home_cell_particle_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .motion_update_enable(motion_update_enable),
    .bus(bus),
    .particle_count(particle_count),
    .busy(busy),
    .done(done),
    .count_err(count_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst) bus.cache_rd_data <= '0;
    else if (bus.cache_rden) bus.cache_rd_data <= mem[bus.cache_rd_address];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && dut.push) check("fifo_overflow", 128'(dut.stored == 2'd2), 0);
  function automatic logic [3*DW-1:0] pdata(input int id);
    return {DW'(id) + 32'h3000_0000, DW'(id) + 32'h2000_0000, DW'(id) + 32'h1000_0000};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int n);
    mem[0] = 96'(n);
    for (int i = 1; i < 256; i++) mem[i] = pdata(i);
  endtask
  task automatic clear;
    for (int i = 0; i < 32; i++) begin
      exp_id[i] = 0;
      exp_addr[i] = -1;
      rdy[i] = 1'b1;
    end
    done_c = 0;
  endtask
  task automatic run_table(input string tag, input int ncyc);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      bus.in_ready = rdy[c];
      check($sformatf("%s_rden_c%0d", tag, c), 128'(bus.cache_rden), 128'(exp_addr[c] >= 0));
      if (exp_addr[c] >= 0) check($sformatf("%s_addr_c%0d", tag, c), 128'(bus.cache_rd_address), 128'(exp_addr[c]));
      check($sformatf("%s_valid_c%0d", tag, c), 128'(bus.out_valid), 128'(exp_id[c] != 0));
      if (exp_id[c] != 0) begin
        check($sformatf("%s_id_c%0d", tag, c), 128'(bus.out_particle_id), 128'(exp_id[c]));
        check($sformatf("%s_data_c%0d", tag, c), 128'(bus.out_particle_data), 128'(pdata(exp_id[c])));
      end
      check($sformatf("%s_done_c%0d", tag, c), 128'(done), 128'(c == done_c));
      tick;
    end
    bus.in_ready = 1'b1;
  endtask
  initial begin
    int got, order_err;
    logic seen_done;
    bus.in_ready = 1'b1;
    fill(5);
    tick; tick; tick;
    check("rst_busy", 128'(busy), 0);
    check("rst_rden", 128'(bus.cache_rden), 0);
    check("rst_addr", 128'(bus.cache_rd_address), 0);
    check("rst_valid", 128'(bus.out_valid), 0);
    check("rst_done", 128'(done), 0);
    check("rst_count", 128'(particle_count), 0);
    check("rst_err", 128'(count_err), 0);
    rst = 1'b0;
    tick;
    clear;
    exp_addr[1] = 0;
    for (int c = 3; c <= 7; c++) exp_addr[c] = c - 2;
    for (int c = 4; c <= 8; c++) exp_id[c] = c - 3;
    done_c = 9;
    run_table("full", 10);
    check("full_count", 128'(particle_count), 5);
    check("full_busy_after", 128'(busy), 0);
    fill(4);
    clear;
    exp_addr[1] = 0; exp_addr[3] = 1; exp_addr[4] = 2; exp_addr[5] = 3; exp_addr[9] = 4;
    exp_id[4] = 1; exp_id[5] = 2; exp_id[6] = 2; exp_id[7] = 2; exp_id[8] = 2; exp_id[9] = 3; exp_id[10] = 4;
    rdy[5] = 1'b0; rdy[6] = 1'b0; rdy[7] = 1'b0;
    done_c = 11;
    run_table("bp", 12);
    fill(0);
    clear;
    exp_addr[1] = 0;
    done_c = 3;
    run_table("empty", 5);
    check("empty_count", 128'(particle_count), 0);
    fill(300);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    check("bad_err", 128'(count_err), 1);
    check("bad_count", 128'(particle_count), PN);
    got = 0;
    order_err = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 600 && !seen_done; i++) begin
      if (bus.out_valid && bus.in_ready) begin
        got++;
        if (bus.out_particle_id != AW'(got) || bus.out_particle_data != pdata(got)) order_err++;
      end
      seen_done = done;
      tick;
    end
    check("bad_done_seen", 128'(seen_done), 1);
    check("bad_pops", 128'(got), PN);
    check("bad_order", 128'(order_err), 0);
    check("bad_err_sticky", 128'(count_err), 1);
    fill(2);
    clear;
    exp_addr[1] = 0; exp_addr[3] = 1; exp_addr[4] = 2;
    exp_id[4] = 1; exp_id[5] = 2;
    done_c = 6;
    run_table("after_bad", 7);
    check("after_bad_err", 128'(count_err), 0);
    fill(221);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    check("over_err", 128'(count_err), 1);
    check("over_count", 128'(particle_count), PN);
    tick; tick;
    motion_update_enable = 1'b1;
    tick;
    motion_update_enable = 1'b0;
    check("over_abort_busy", 128'(busy), 0);
    check("over_abort_valid", 128'(bus.out_valid), 0);
    check("over_abort_err_kept", 128'(count_err), 1);
    check("over_abort_count_kept", 128'(particle_count), PN);
    fill(6);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick; tick; tick;
    check("abort_id3", 128'(bus.out_particle_id), 3);
    tick;
    motion_update_enable = 1'b1;
    tick;
    check("abort_busy", 128'(busy), 0);
    check("abort_valid", 128'(bus.out_valid), 0);
    check("abort_rden", 128'(bus.cache_rden), 0);
    check("abort_done", 128'(done), 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("abort_start_ign_busy", 128'(busy), 0);
    check("abort_start_ign_rden", 128'(bus.cache_rden), 0);
    check("abort_start_ign_done", 128'(done), 0);
    motion_update_enable = 1'b0;
    tick;
    clear;
    exp_addr[1] = 0;
    for (int c = 3; c <= 8; c++) exp_addr[c] = c - 2;
    for (int c = 4; c <= 9; c++) exp_id[c] = c - 3;
    done_c = 10;
    run_table("restart", 11);
    check("restart_count", 128'(particle_count), 6);
    fill(5);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_start_ign_rden", 128'(bus.cache_rden), 1);
    check("busy_start_ign_addr", 128'(bus.cache_rd_address), 3);
    check("busy_start_ign_id", 128'(bus.out_particle_id), 2);
    rst = 1'b1;
    tick;
    check("midrst_busy", 128'(busy), 0);
    check("midrst_rden", 128'(bus.cache_rden), 0);
    check("midrst_addr", 128'(bus.cache_rd_address), 0);
    check("midrst_valid", 128'(bus.out_valid), 0);
    check("midrst_id", 128'(bus.out_particle_id), 0);
    check("midrst_data", 128'(bus.out_particle_data), 0);
    check("midrst_done", 128'(done), 0);
    check("midrst_count", 128'(particle_count), 0);
    check("midrst_err", 128'(count_err), 0);
    rst = 1'b0;
    tick;
    check("midrst_idle", 128'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
